// File: rtl/frame_replay_buffer.sv
// Frame replay buffer: captures one frame from a vld/rdy source into local
// memory, then streams it out cfg_repeat+1 times with fst on word 0 of each pass.
module frame_replay_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    cfg_frame_len,
  input  logic [7:0]       cfg_repeat,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_fst,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_fst,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             frame_done,
  output logic             resync_err,
  output logic [15:0]      frame_cnt
);

  typedef enum logic {LOAD, PLAY} state_t;

  state_t           state, state_n;
  logic [AW-1:0]    wr_ptr, rd_ptr, len_q, wr_idx, eff_len;
  logic [7:0]       rep_q, rep_cnt;
  logic             wr_en, resync, wr_last, rd_en, rd_last, pass_last, cfg_open;
  logic [WIDTH-1:0] mem [DEPTH];

  // Config is only sampled while no word of the current frame is held, so a
  // fresh frame (or a resync restart) picks up cfg but mid-frame edits do not.
  assign cfg_open = (state == LOAD) && ((wr_ptr == '0) || resync);

  assign out_data = mem[rd_ptr];
  assign out_fst  = out_vld && (rd_ptr == '0);

  // Next-state and handshake decode; the last-word compare uses the length
  // being latched this cycle so a 1-word frame completes on its first write.
  always_comb begin
    state_n   = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    wr_en     = 1'b0;
    resync    = 1'b0;
    rd_en     = 1'b0;
    wr_idx    = wr_ptr;
    eff_len   = len_q;
    wr_last   = 1'b0;
    rd_last   = (rd_ptr == len_q);
    pass_last = (rep_cnt == rep_q);
    case (state)
      LOAD: begin
        in_rdy = !reset;
        wr_en  = in_vld && in_rdy;
        resync = wr_en && in_fst && (wr_ptr != '0);
        if (resync) wr_idx = '0;
        if ((wr_ptr == '0) || resync) eff_len = cfg_frame_len;
        wr_last = wr_en && (wr_idx == eff_len);
        if (wr_last) state_n = PLAY;
      end
      PLAY: begin
        out_vld = 1'b1;
        rd_en   = out_rdy;
        if (rd_en && rd_last && pass_last) state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_n;
  end

  // Pointers, pass counter, config latches and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rep_cnt    <= '0;
      len_q      <= '0;
      rep_q      <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      resync_err <= resync;
      if (cfg_open) begin
        len_q <= cfg_frame_len;
        rep_q <= cfg_repeat;
      end
      if (wr_en) begin
        if (wr_last) begin
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          rep_cnt <= '0;
        end else if (resync) begin
          wr_ptr <= AW'(1);
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (rd_en) begin
        if (rd_last) begin
          rd_ptr <= '0;
          if (pass_last) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
          end else begin
            rep_cnt <= rep_cnt + 8'd1;
          end
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  // Frame storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= in_data;
  end

endmodule

// File: tb/tb_frame_replay_buffer.sv
// Scoreboard bench for frame_replay_buffer: expected words are queued as each
// frame is loaded and compared as the buffer emits them.
module tb_frame_replay_buffer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [AW-1:0]    cfg_frame_len = '0;
  logic [7:0]       cfg_repeat = '0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_fst = 1'b0;
  logic             in_vld = 1'b0;
  logic             in_rdy;
  logic [WIDTH-1:0] out_data;
  logic             out_fst;
  logic             out_vld;
  logic             out_rdy = 1'b0;
  logic             frame_done;
  logic             resync_err;
  logic [15:0]      frame_cnt;

  int checks = 0;
  int failures = 0;
  int rs_cnt = 0;
  int exp_frames = 0;
  logic [WIDTH:0] sbq[$];

  frame_replay_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .cfg_frame_len(cfg_frame_len), .cfg_repeat(cfg_repeat),
    .in_data(in_data), .in_fst(in_fst), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_fst(out_fst), .out_vld(out_vld), .out_rdy(out_rdy),
    .frame_done(frame_done), .resync_err(resync_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One clock: inputs change 1ns after the edge; resync pulses are tallied.
  task automatic cycle();
    @(posedge clk); #1;
    if (resync_err === 1'b1) rs_cnt++;
  endtask

  task automatic drive_words(input logic [31:0] base, input int n, input int fst_idx);
    for (int i = 0; i < n; i++) begin
      in_vld  = 1'b1;
      in_data = base + 32'(i);
      in_fst  = (i == fst_idx);
      cycle();
    end
    in_vld = 1'b0;
    in_fst = 1'b0;
  endtask

  task automatic push_frame(input logic [31:0] base, input int n, input int rep);
    logic [31:0] d;
    for (int r = 0; r <= rep; r++)
      for (int i = 0; i < n; i++) begin
        d = base + 32'(i);
        sbq.push_back({d, (i == 0)});
      end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    checks++;
    if ({in_rdy, out_vld, out_fst, frame_done, resync_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got rdy/vld/fst/done/rs=%b want 00000",
               {in_rdy, out_vld, out_fst, frame_done, resync_err});
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt);
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      failures++; $display("FAIL reset_release got in_rdy=%b out_vld=%b want 1/0", in_rdy, out_vld);
    end
  endtask

  // T1: single pass, fst once, frame_done one cycle after last output.
  task automatic test_single_pass();
    int cyc = 0, n_out = 0, n_fst = 0, n_done = 0, last_cyc = -1, done_cyc = -1, idle_vld = 0;
    logic [WIDTH:0] exp;
    cfg_frame_len = 6'd35; cfg_repeat = 8'd0;
    push_frame(32'h3F80_0000, 36, 0);
    drive_words(32'h3F80_0000, 36, 0);
    checks++;
    if (out_vld !== 1'b1) begin
      failures++; $display("FAIL t1_first_vld got %b want 1", out_vld);
    end
    out_rdy = 1'b1;
    while ((sbq.size() > 0 || n_done == 0) && cyc < 500) begin
      @(negedge clk);
      if (out_vld && out_rdy) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++; $display("FAIL t1_extra_output got %h", out_data);
        end else begin
          exp = sbq.pop_front();
          if ({out_data, out_fst} !== exp) begin
            failures++; $display("FAIL t1_word got %h/%b want %h/%b", out_data, out_fst, exp[WIDTH:1], exp[0]);
          end
        end
        n_out++; if (out_fst) n_fst++; last_cyc = cyc;
      end
      if (frame_done) begin n_done++; done_cyc = cyc; end
      cycle(); cyc++;
    end
    exp_frames++;
    repeat (3) begin
      @(negedge clk);
      if (frame_done) n_done++;
      if (out_vld) idle_vld++;
      cycle();
    end
    checks++;
    if (n_out !== 36 || n_fst !== 1) begin
      failures++; $display("FAIL t1_counts got out=%0d fst=%0d want 36/1", n_out, n_fst);
    end
    checks++;
    if (n_done !== 1 || done_cyc !== last_cyc + 1) begin
      failures++; $display("FAIL t1_done got n=%0d at %0d want 1 at %0d", n_done, done_cyc, last_cyc + 1);
    end
    checks++;
    if (idle_vld !== 0) begin
      failures++; $display("FAIL t1_idle_after got vld cycles=%0d want 0", idle_vld);
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      failures++; $display("FAIL t1_frame_cnt got %0d want %0d", frame_cnt, exp_frames);
    end
  endtask

  // T2: three passes with free-flowing output.
  task automatic test_repeat();
    int cyc = 0, n_out = 0, n_fst = 0, n_done = 0;
    logic [WIDTH:0] exp;
    cfg_frame_len = 6'd35; cfg_repeat = 8'd2;
    push_frame(32'h3F80_0000, 36, 2);
    drive_words(32'h3F80_0000, 36, 0);
    out_rdy = 1'b1;
    while ((sbq.size() > 0 || n_done == 0) && cyc < 500) begin
      @(negedge clk);
      if (out_vld && out_rdy) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++; $display("FAIL t2_extra_output got %h", out_data);
        end else begin
          exp = sbq.pop_front();
          if ({out_data, out_fst} !== exp) begin
            failures++; $display("FAIL t2_word #%0d got %h/%b want %h/%b", n_out, out_data, out_fst, exp[WIDTH:1], exp[0]);
          end
        end
        n_out++; if (out_fst) n_fst++;
      end
      if (frame_done) n_done++;
      cycle(); cyc++;
    end
    exp_frames++;
    checks++;
    if (n_out !== 108 || n_fst !== 3 || n_done !== 1) begin
      failures++; $display("FAIL t2_counts got out=%0d fst=%0d done=%0d want 108/3/1", n_out, n_fst, n_done);
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      failures++; $display("FAIL t2_frame_cnt got %0d want %0d", frame_cnt, exp_frames);
    end
  endtask

  // T3: same as T2 with random back-pressure; outputs must hold while stalled.
  task automatic test_stall();
    int cyc = 0, n_out = 0, n_fst = 0, n_done = 0, bad_hold = 0, bad_rdy = 0;
    logic stalled = 1'b0;
    logic [WIDTH:0] held = '0, exp;
    cfg_frame_len = 6'd35; cfg_repeat = 8'd2;
    push_frame(32'h3F80_0000, 36, 2);
    drive_words(32'h3F80_0000, 36, 0);
    while ((sbq.size() > 0 || n_done == 0) && cyc < 2000) begin
      out_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled && {out_data, out_fst} !== held) bad_hold++;
      if (out_vld && in_rdy !== 1'b0) bad_rdy++;
      if (out_vld && out_rdy) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++; $display("FAIL t3_extra_output got %h", out_data);
        end else begin
          exp = sbq.pop_front();
          if ({out_data, out_fst} !== exp) begin
            failures++; $display("FAIL t3_word #%0d got %h/%b want %h/%b", n_out, out_data, out_fst, exp[WIDTH:1], exp[0]);
          end
        end
        n_out++; if (out_fst) n_fst++;
      end
      stalled = out_vld && !out_rdy;
      held = {out_data, out_fst};
      if (frame_done) n_done++;
      cycle(); cyc++;
    end
    out_rdy = 1'b1;
    exp_frames++;
    checks++;
    if (n_out !== 108 || n_fst !== 3 || n_done !== 1) begin
      failures++; $display("FAIL t3_counts got out=%0d fst=%0d done=%0d want 108/3/1", n_out, n_fst, n_done);
    end
    checks++;
    if (bad_hold !== 0) begin
      failures++; $display("FAIL t3_stall_hold got %0d unstable cycles want 0", bad_hold);
    end
    checks++;
    if (bad_rdy !== 0) begin
      failures++; $display("FAIL t3_in_rdy_play got %0d cycles high want 0", bad_rdy);
    end
  endtask

  // T4: in_fst at word 10 restarts the frame; earlier words never replay.
  task automatic test_resync();
    int cyc = 0, n_out = 0, n_done = 0;
    logic [WIDTH:0] exp;
    cfg_frame_len = 6'd35; cfg_repeat = 8'd0;
    rs_cnt = 0;
    drive_words(32'hDEAD_0000, 10, 0);
    checks++;
    if (rs_cnt !== 0) begin
      failures++; $display("FAIL t4_early_resync got %0d want 0", rs_cnt);
    end
    push_frame(32'h4000_0000, 36, 0);
    drive_words(32'h4000_0000, 36, 0);
    out_rdy = 1'b1;
    while ((sbq.size() > 0 || n_done == 0) && cyc < 500) begin
      @(negedge clk);
      if (out_vld && out_rdy) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++; $display("FAIL t4_extra_output got %h", out_data);
        end else begin
          exp = sbq.pop_front();
          if ({out_data, out_fst} !== exp) begin
            failures++; $display("FAIL t4_word #%0d got %h/%b want %h/%b", n_out, out_data, out_fst, exp[WIDTH:1], exp[0]);
          end
        end
        n_out++;
      end
      if (frame_done) n_done++;
      cycle(); cyc++;
    end
    exp_frames++;
    checks++;
    if (rs_cnt !== 1) begin
      failures++; $display("FAIL t4_resync_count got %0d want 1", rs_cnt);
    end
    checks++;
    if (n_out !== 36 || frame_cnt !== 16'(exp_frames)) begin
      failures++; $display("FAIL t4_counts got out=%0d frames=%0d want 36/%0d", n_out, frame_cnt, exp_frames);
    end
  endtask

  // T5: shortest and longest frames.
  task automatic test_len_edges();
    int cyc, n_out, n_fst, n_done;
    logic [WIDTH:0] exp;
    for (int k = 0; k < 2; k++) begin
      cyc = 0; n_out = 0; n_fst = 0; n_done = 0;
      cfg_frame_len = (k == 0) ? 6'd0 : 6'd63;
      cfg_repeat    = (k == 0) ? 8'd3 : 8'd1;
      push_frame(32'h1111_0000 + 32'(k << 8), (k == 0) ? 1 : 64, (k == 0) ? 3 : 1);
      drive_words(32'h1111_0000 + 32'(k << 8), (k == 0) ? 1 : 64, 0);
      out_rdy = 1'b1;
      while ((sbq.size() > 0 || n_done == 0) && cyc < 500) begin
        @(negedge clk);
        if (out_vld && out_rdy) begin
          checks++;
          if (sbq.size() == 0) begin
            failures++; $display("FAIL t5_extra_output len%0d got %h", k, out_data);
          end else begin
            exp = sbq.pop_front();
            if ({out_data, out_fst} !== exp) begin
              failures++; $display("FAIL t5_word len%0d #%0d got %h/%b want %h/%b", k, n_out, out_data, out_fst, exp[WIDTH:1], exp[0]);
            end
          end
          n_out++; if (out_fst) n_fst++;
        end
        if (frame_done) n_done++;
        cycle(); cyc++;
      end
      exp_frames++;
      checks++;
      if (k == 0 && (n_out !== 4 || n_fst !== 4)) begin
        failures++; $display("FAIL t5_len1_counts got out=%0d fst=%0d want 4/4", n_out, n_fst);
      end else if (k == 1 && (n_out !== 128 || n_fst !== 2)) begin
        failures++; $display("FAIL t5_len64_counts got out=%0d fst=%0d want 128/2", n_out, n_fst);
      end
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      failures++; $display("FAIL t5_frame_cnt got %0d want %0d", frame_cnt, exp_frames);
    end
  endtask

  // T6: reset in the middle of the second pass, then a clean frame.
  task automatic test_reset_mid();
    int cyc = 0, n_out = 0, n_done = 0;
    logic [WIDTH:0] exp;
    cfg_frame_len = 6'd35; cfg_repeat = 8'd1;
    push_frame(32'h2000_0000, 36, 1);
    drive_words(32'h2000_0000, 36, 0);
    out_rdy = 1'b1;
    while (n_out < 56 && cyc < 500) begin
      @(negedge clk);
      if (out_vld && out_rdy) begin
        exp = sbq.pop_front();
        checks++;
        if ({out_data, out_fst} !== exp) begin
          failures++; $display("FAIL t6_word #%0d got %h/%b want %h/%b", n_out, out_data, out_fst, exp[WIDTH:1], exp[0]);
        end
        n_out++;
      end
      if (n_out < 56) begin cycle(); cyc++; end
    end
    out_rdy = 1'b0;
    reset = 1'b1;
    cycle();
    checks++;
    if (out_vld !== 1'b0 || frame_cnt !== 16'd0 || frame_done !== 1'b0 || in_rdy !== 1'b0) begin
      failures++;
      $display("FAIL t6_reset_mid got vld=%b cnt=%0d done=%b rdy=%b want 0/0/0/0", out_vld, frame_cnt, frame_done, in_rdy);
    end
    reset = 1'b0;
    sbq.delete();
    exp_frames = 0;
    cycle();
    checks++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      failures++; $display("FAIL t6_after_release got rdy=%b vld=%b want 1/0", in_rdy, out_vld);
    end
    cyc = 0; n_out = 0;
    cfg_frame_len = 6'd9; cfg_repeat = 8'd1;
    push_frame(32'h5000_0000, 10, 1);
    drive_words(32'h5000_0000, 10, 0);
    out_rdy = 1'b1;
    while ((sbq.size() > 0 || n_done == 0) && cyc < 500) begin
      @(negedge clk);
      if (out_vld && out_rdy) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++; $display("FAIL t6_extra_output got %h", out_data);
        end else begin
          exp = sbq.pop_front();
          if ({out_data, out_fst} !== exp) begin
            failures++; $display("FAIL t6_reload_word #%0d got %h/%b want %h/%b", n_out, out_data, out_fst, exp[WIDTH:1], exp[0]);
          end
        end
        n_out++;
      end
      if (frame_done) n_done++;
      cycle(); cyc++;
    end
    exp_frames++;
    checks++;
    if (n_out !== 20 || n_done !== 1 || frame_cnt !== 16'(exp_frames)) begin
      failures++; $display("FAIL t6_reload_counts got out=%0d done=%0d cnt=%0d want 20/1/%0d", n_out, n_done, frame_cnt, exp_frames);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_pass();
    test_repeat();
    test_stall();
    test_resync();
    test_len_edges();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
